// File: rtl/qed_pkg.sv
// Shared definitions for the QED front-end control blocks.
// Holds the duplicate-scheduler state encoding and the RV32 opcodes that
// terminate an original-instruction block.

package qed_pkg;

    // Scheduler state encoding; kept as plain 2-bit constants so older blocks
    // that decode ctrl_state numerically keep working.
    typedef logic [1:0] state_t;

    localparam state_t StOff    = 2'd0;
    localparam state_t StOrig   = 2'd1;
    localparam state_t StDup    = 2'd2;
    localparam state_t StSettle = 2'd3;

    // RV32 major opcodes (instruction bits [6:0]) that close a block.
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/qed_sync_detect.sv
// Combinational opcode classifier.
// Flags control-flow and ordering instructions after which an original block
// must be closed so its duplicates replay before the flow diverges.
//
// Ports:
//   opcode  - instruction bits [6:0]
//   sync_op - 1 when opcode is BRANCH, JAL, JALR, FENCE or SYSTEM

module qed_sync_detect
    import qed_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       sync_op
);

    always_comb begin
        sync_op = 1'b0;
        case (opcode)
            OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_FENCE, OPC_SYSTEM: sync_op = 1'b1;
            default:                                              sync_op = 1'b0;
        endcase
    end

endmodule

// File: rtl/qed_dup_sched.sv
// QED duplicate scheduler.
// Lets a block of original instructions through to the pipeline, then holds
// the front end in duplicate mode until exactly that many duplicates have
// been accepted, then idles for a settle window before the next block.
//
// Ports:
//   clk, rst             - clock; asynchronous active-low reset
//   ena                  - QED enable
//   ifu_vld              - fetch offers a valid original instruction
//   ifu_qed_instruction  - fetched instruction (only the opcode is used)
//   stall_IF             - fetch stalled, nothing accepted this cycle
//   vld_out              - duplicate cache has a duplicate available
//   exec_dup             - registered; high exactly while in DUP
//   blk_len              - length of the current / last block
//   blk_done             - pulse in the cycle the last duplicate is accepted
//   dup_timeout          - sticky replay-timeout error, cleared by reset only
//   ctrl_state           - OFF=0, ORIG=1, DUP=2, SETTLE=3

module qed_dup_sched
    import qed_pkg::*;
#(
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned TIMEOUT       = 64,
    parameter int unsigned CW            = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          ifu_vld,
    input  logic [31:0]   ifu_qed_instruction,
    input  logic          stall_IF,
    input  logic          vld_out,
    output logic          exec_dup,
    output logic [CW-1:0] blk_len,
    output logic          blk_done,
    output logic          dup_timeout,
    output logic [1:0]    ctrl_state
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   blk_len_q, blk_len_d;
    logic [CW-1:0]   rem_q, rem_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic            exec_dup_q;
    logic            dup_timeout_q, dup_timeout_d;

    logic            sync_op;
    logic            orig_fire;
    logic            dup_fire;
    logic [CW-1:0]   len_next;

    // Only the opcode field matters here.
    logic            unused_instr_bits;
    assign unused_instr_bits = ^ifu_qed_instruction[31:7];

    qed_sync_detect u_sync_detect (
        .opcode  (ifu_qed_instruction[6:0]),
        .sync_op (sync_op)
    );

    assign orig_fire = ifu_vld & ~stall_IF & (state_q == StOrig);
    assign dup_fire  = vld_out & ~stall_IF & (state_q == StDup);

    // Block length after this cycle's fire, saturating at DEPTH.
    always_comb begin
        len_next = blk_len_q;
        if (orig_fire && (blk_len_q != CW'(DEPTH))) begin
            len_next = blk_len_q + CW'(1);
        end
    end

    always_comb begin
        state_d       = state_q;
        blk_len_d     = blk_len_q;
        rem_d         = rem_q;
        to_cnt_d      = to_cnt_q;
        settle_d      = settle_q;
        dup_timeout_d = dup_timeout_q;

        case (state_q)
            StOff: begin
                if (ena) begin
                    state_d   = StOrig;
                    blk_len_d = '0;
                end
            end

            StOrig: begin
                blk_len_d = len_next;
                // A fire that fills the block or closes it with a sync op, or
                // losing enable with a partial block, hands over to replay.
                // An instruction accepted in the same cycle ena falls still counts.
                if ((orig_fire && ((len_next == CW'(DEPTH)) || sync_op)) ||
                    (!ena && (len_next != '0))) begin
                    state_d  = StDup;
                    rem_d    = len_next;
                    to_cnt_d = '0;
                end else if (!ena) begin
                    state_d = StOff;
                end
            end

            StDup: begin
                // ena is deliberately ignored: a started block always completes.
                if (dup_fire) begin
                    rem_d    = rem_q - CW'(1);
                    to_cnt_d = '0;
                    if (rem_q == CW'(1)) begin
                        state_d  = StSettle;
                        settle_d = '0;
                    end
                end else if (!stall_IF) begin
                    // Unstalled with no duplicate available; stalls freeze the count.
                    if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                        to_cnt_d      = TW'(TIMEOUT);
                        dup_timeout_d = 1'b1;
                        state_d       = StSettle;
                        settle_d      = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + TW'(1);
                    end
                end
            end

            StSettle: begin
                if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                    if (ena) begin
                        state_d   = StOrig;
                        blk_len_d = '0;
                    end else begin
                        state_d = StOff;
                    end
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end

            default: state_d = StOff;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StOff;
            blk_len_q     <= '0;
            rem_q         <= '0;
            to_cnt_q      <= '0;
            settle_q      <= '0;
            exec_dup_q    <= 1'b0;
            dup_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            blk_len_q     <= blk_len_d;
            rem_q         <= rem_d;
            to_cnt_q      <= to_cnt_d;
            settle_q      <= settle_d;
            exec_dup_q    <= (state_d == StDup);
            dup_timeout_q <= dup_timeout_d;
        end
    end

    assign exec_dup    = exec_dup_q;
    assign blk_len     = blk_len_q;
    assign blk_done    = dup_fire & (rem_q == CW'(1));
    assign dup_timeout = dup_timeout_q;
    assign ctrl_state  = state_q;

endmodule

// File: tb/tb_qed_dup_sched.sv
// Self-checking bench for qed_dup_sched: directed scenarios followed by
// randomized blocks checked against a block-level reference model.

module tb_qed_dup_sched;

    localparam int DEPTH  = 16;
    localparam int SETTLE = 4;
    localparam int TMO    = 64;
    localparam int CW     = $clog2(DEPTH + 1);

    localparam logic [31:0] ADDI = 32'h00100093;
    localparam logic [31:0] BEQ  = 32'h00208063;
    localparam logic [31:0] JAL  = 32'h0000006f;
    localparam logic [31:0] JALR = 32'h00008067;
    localparam logic [31:0] FENC = 32'h0000000f;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ena = 1'b0;
    logic          ifu_vld = 1'b0;
    logic [31:0]   instr = 32'h0;
    logic          stall_IF = 1'b0;
    logic          vld_out = 1'b0;
    logic          exec_dup;
    logic [CW-1:0] blk_len;
    logic          blk_done;
    logic          dup_timeout;
    logic [1:0]    ctrl_state;

    int n_cmp = 0;
    int n_err = 0;
    bit exp_to = 1'b0;
    logic [31:0] blk[$];

    qed_dup_sched #(
        .DEPTH         (DEPTH),
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT       (TMO)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ena                 (ena),
        .ifu_vld             (ifu_vld),
        .ifu_qed_instruction (instr),
        .stall_IF            (stall_IF),
        .vld_out             (vld_out),
        .exec_dup            (exec_dup),
        .blk_len             (blk_len),
        .blk_done            (blk_done),
        .dup_timeout         (dup_timeout),
        .ctrl_state          (ctrl_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_sync(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        return op inside {7'b1100011, 7'b1101111, 7'b1100111, 7'b0001111, 7'b1110011};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [8];
        logic [31:0] w;
        ops = '{7'b1100011, 7'b1101111, 7'b1100111, 7'b0001111, 7'b1110011,
                7'b0010011, 7'b0110011, 7'b0000011};
        w = $urandom;
        if ($urandom_range(0, 6) == 0) w[6:0] = ops[$urandom_range(0, 4)];
        else                           w[6:0] = ops[$urandom_range(5, 7)];
        return w;
    endfunction

    // Block length from the rules: closes at the first sync op (inclusive) or
    // at DEPTH; otherwise the whole list, ended by dropping ena (nat=0).
    function automatic void model_len(output int len, output bit nat);
        len = blk.size();
        nat = 1'b0;
        for (int i = 0; i < blk.size(); i++) begin
            if (is_sync(blk[i]) || (i + 1 == DEPTH)) begin
                len = i + 1;
                nat = 1'b1;
                return;
            end
        end
    endfunction

    task automatic fill(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) blk.push_back(w);
    endtask

    // Feed the block in ORIG until the scheduler enters DUP.
    task automatic feed(input bit rnd, input bit drop_same, output int len);
        int idx = 0;
        int cyc = 0;
        bit nat;
        bit fire;
        model_len(len, nat);
        chk("feed_start_state", 32'(ctrl_state), 32'd1);
        while (idx < len && cyc < 400) begin
            ena = 1'b1; instr = blk[idx]; ifu_vld = 1'b1; stall_IF = 1'b0;
            vld_out = 1'($urandom_range(0, 1));
            if (rnd) begin
                ifu_vld  = ($urandom_range(0, 3) != 0);
                stall_IF = ($urandom_range(0, 4) == 0);
            end
            if (!nat && drop_same && idx == len - 1) begin
                ena = 1'b0; ifu_vld = 1'b1; stall_IF = 1'b0;
            end
            fire = ifu_vld && !stall_IF;
            tick();
            cyc++;
            if (fire) idx++;
            if (idx < len || (!nat && !drop_same)) begin
                chk("orig_state", 32'(ctrl_state), 32'd1);
                chk("orig_exec_dup", 32'(exec_dup), 32'd0);
                chk("orig_blk_len", 32'(blk_len), 32'(idx));
            end
        end
        if (idx < len) chk("feed_bound", 32'(idx), 32'(len));
        if (!nat && !drop_same) begin
            ena = 1'b0; ifu_vld = 1'b0;
            tick();
        end
        chk("dup_entry_state", 32'(ctrl_state), 32'd2);
        chk("dup_entry_exec", 32'(exec_dup), 32'd1);
        chk("dup_entry_len", 32'(blk_len), 32'(len));
    endtask

    // Replay duplicates until the block completes; optionally hold a 10-cycle
    // stall once stall_at duplicates have been accepted.
    task automatic replay(input int len, input bit rnd, input int stall_at, output int cyc);
        int cnt = 0;
        int stalled = 0;
        bit fire;
        cyc = 0;
        while (cnt < len && cyc < 600) begin
            vld_out = 1'b1; stall_IF = 1'b0;
            ifu_vld = 1'($urandom_range(0, 1)); instr = rand_instr();
            if (rnd) begin
                vld_out  = ($urandom_range(0, 2) != 0);
                stall_IF = ($urandom_range(0, 5) == 0);
                ena      = 1'($urandom_range(0, 1));
            end
            if (stall_at >= 0 && cnt == stall_at && stalled < 10) begin
                stall_IF = 1'b1;
                stalled++;
            end
            fire = vld_out && !stall_IF;
            #1;
            chk("blk_done", 32'(blk_done), 32'(fire && (cnt == len - 1)));
            tick();
            cyc++;
            if (fire) cnt++;
            if (cnt < len) begin
                chk("dup_state", 32'(ctrl_state), 32'd2);
                chk("dup_exec", 32'(exec_dup), 32'd1);
            end else begin
                chk("post_dup_state", 32'(ctrl_state), 32'd3);
                chk("post_dup_exec", 32'(exec_dup), 32'd0);
                chk("post_dup_len", 32'(blk_len), 32'(len));
            end
        end
        if (cnt < len) chk("replay_bound", 32'(cnt), 32'(len));
        chk("replay_timeout_flag", 32'(dup_timeout), 32'(exp_to));
    endtask

    // SETTLE lasts exactly SETTLE cycles regardless of stalls.
    task automatic settle(input bit en, input int len);
        ena = en;
        for (int i = 0; i < SETTLE; i++) begin
            stall_IF = 1'($urandom_range(0, 1));
            ifu_vld  = 1'($urandom_range(0, 1));
            vld_out  = 1'($urandom_range(0, 1));
            chk("settle_state", 32'(ctrl_state), 32'd3);
            chk("settle_exec", 32'(exec_dup), 32'd0);
            tick();
        end
        chk("after_settle_state", 32'(ctrl_state), en ? 32'd1 : 32'd0);
        chk("after_settle_len", 32'(blk_len), en ? 32'd0 : 32'(len));
        chk("after_settle_timeout", 32'(dup_timeout), 32'(exp_to));
    endtask

    task automatic wake();
        if (ctrl_state == 2'd0) begin
            ena = 1'b1; ifu_vld = 1'b0;
            tick();
            chk("wake_state", 32'(ctrl_state), 32'd1);
            chk("wake_len", 32'(blk_len), 32'd0);
        end
    endtask

    initial begin
        int len;
        int cyc;

        // Reset state, ena high must not matter while reset is held.
        #1 rst = 1'b0;
        ena = 1'b1; ifu_vld = 1'b1; vld_out = 1'b1;
        tick(); tick();
        chk("rst_state", 32'(ctrl_state), 32'd0);
        chk("rst_exec", 32'(exec_dup), 32'd0);
        chk("rst_len", 32'(blk_len), 32'd0);
        chk("rst_done", 32'(blk_done), 32'd0);
        chk("rst_timeout", 32'(dup_timeout), 32'd0);
        ena = 1'b0; ifu_vld = 1'b0; vld_out = 1'b0;
        rst = 1'b1;
        tick();
        chk("off_idle", 32'(ctrl_state), 32'd0);
        wake();

        // Full DEPTH block back to back.
        blk.delete(); fill(ADDI, DEPTH);
        feed(1'b0, 1'b0, len);
        chk("full_len", 32'(len), 32'(DEPTH));
        replay(len, 1'b0, -1, cyc);
        chk("full_dup_cycles", 32'(cyc), 32'(DEPTH));
        settle(1'b1, len);

        // Three ADDI then BEQ closes a 4-long block.
        blk.delete(); fill(ADDI, 3); blk.push_back(BEQ); fill(ADDI, 2);
        feed(1'b1, 1'b0, len);
        chk("beq_len", 32'(len), 32'd4);
        replay(len, 1'b1, -1, cyc);
        settle(1'b1, len);

        // Stall of 10 cycles mid-replay of a 5-long block.
        blk.delete(); fill(ADDI, 4); blk.push_back(JAL);
        feed(1'b0, 1'b0, len);
        replay(len, 1'b0, 2, cyc);
        chk("stall_dup_cycles", 32'(cyc), 32'd15);
        settle(1'b1, len);

        // Replay starvation: 64 unstalled cycles without vld_out, with a
        // 5-cycle stall in the middle that must neither count nor clear.
        blk.delete(); blk.push_back(ADDI); blk.push_back(FENC);
        feed(1'b0, 1'b0, len);
        vld_out = 1'b0; stall_IF = 1'b0; ena = 1'b1;
        for (int i = 1; i <= TMO; i++) begin
            if (i == 30) begin
                stall_IF = 1'b1;
                for (int s = 0; s < 5; s++) tick();
                chk("to_stall_state", 32'(ctrl_state), 32'd2);
                stall_IF = 1'b0;
            end
            ifu_vld = 1'($urandom_range(0, 1));
            #1;
            chk("to_blk_done", 32'(blk_done), 32'd0);
            tick();
            if (i == TMO - 1) begin
                chk("to_pre_state", 32'(ctrl_state), 32'd2);
                chk("to_pre_flag", 32'(dup_timeout), 32'd0);
            end
        end
        exp_to = 1'b1;
        chk("to_state", 32'(ctrl_state), 32'd3);
        chk("to_flag", 32'(dup_timeout), 32'd1);
        chk("to_exec", 32'(exec_dup), 32'd0);
        settle(1'b1, len);

        // ena dropped after two originals: replay 2, settle, OFF.
        blk.delete(); fill(ADDI, 2);
        feed(1'b0, 1'b0, len);
        chk("drop_len", 32'(len), 32'd2);
        replay(len, 1'b0, -1, cyc);
        settle(1'b0, len);

        // ena dropped in ORIG with an empty block.
        ena = 1'b1; ifu_vld = 1'b0;
        tick();
        chk("empty_orig", 32'(ctrl_state), 32'd1);
        ena = 1'b0;
        tick();
        chk("empty_off", 32'(ctrl_state), 32'd0);
        chk("empty_exec", 32'(exec_dup), 32'd0);
        tick();
        chk("empty_exec2", 32'(exec_dup), 32'd0);

        // ena falls in the same cycle as the last original fire.
        wake();
        blk.delete(); fill(ADDI, 3);
        feed(1'b1, 1'b1, len);
        replay(len, 1'b1, -1, cyc);
        settle(1'b1, len);

        // Reset pulled mid-replay with seven duplicates outstanding.
        blk.delete(); fill(ADDI, 6); blk.push_back(JALR);
        feed(1'b0, 1'b0, len);
        vld_out = 1'b1; stall_IF = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst_exec", 32'(exec_dup), 32'd0);
        chk("arst_state", 32'(ctrl_state), 32'd0);
        chk("arst_len", 32'(blk_len), 32'd0);
        chk("arst_done", 32'(blk_done), 32'd0);
        chk("arst_timeout", 32'(dup_timeout), 32'd0);
        exp_to = 1'b0;
        tick();
        rst = 1'b1; ena = 1'b1; ifu_vld = 1'b0;
        tick();
        chk("arst_orig", 32'(ctrl_state), 32'd1);
        chk("arst_orig_len", 32'(blk_len), 32'd0);

        // Randomized blocks.
        for (int b = 0; b < 30; b++) begin
            wake();
            blk.delete();
            for (int k = 0, n = $urandom_range(1, DEPTH + 4); k < n; k++) blk.push_back(rand_instr());
            feed(1'b1, 1'($urandom_range(0, 1)), len);
            replay(len, 1'b1, -1, cyc);
            settle($urandom_range(0, 3) != 0, len);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
